// File: rtl/bank_cmd_scheduler_pkg.sv
// Shared types and default DRAM timing for the per-channel command scheduler.
package bank_cmd_scheduler_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } cmd_type_t;

  typedef enum logic [2:0] {
    ST_NORMAL,
    ST_DRAIN,
    ST_PREA,
    ST_WAIT_RP,
    ST_REF,
    ST_TRFC
  } sched_state_t;

  typedef enum logic [1:0] {
    REQ_ACT = 2'd0,
    REQ_RD  = 2'd1,
    REQ_WR  = 2'd2,
    REQ_PRE = 2'd3
  } req_cmd_t;

  localparam int DEF_CYCLE_TRRD = 4;
  localparam int DEF_CYCLE_TCCD = 4;
  localparam int DEF_CYCLE_TRP  = 10;
  localparam int DEF_CYCLE_TRFC = 88;
  localparam int CNT_W          = 8;

  function automatic cmd_type_t to_bus_cmd(input req_cmd_t c);
    case (c)
      REQ_ACT: return CMD_ACT;
      REQ_RD:  return CMD_RD;
      REQ_WR:  return CMD_WR;
      default: return CMD_PRE;
    endcase
  endfunction

endpackage

// File: rtl/bank_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set bit of elig starting at rr_ptr.
module bank_cmd_scheduler_rr_arbiter #(
  parameter int NUM_BANKS = 8,
  parameter int BA_W      = 3
) (
  input  logic [NUM_BANKS-1:0] elig,
  input  logic [BA_W-1:0]      rr_ptr,
  output logic [NUM_BANKS-1:0] grant,
  output logic [BA_W-1:0]      grant_idx,
  output logic                 any_grant
);

  always_comb begin
    logic [BA_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      idx = rr_ptr + BA_W'(i);
      if (!any_grant && elig[idx]) begin
        any_grant  = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Shares one DRAM command bus among per-bank requesters and owns the refresh
// sequence (drain, optional precharge-all, REF, tRFC wait).
module bank_cmd_scheduler
  import bank_cmd_scheduler_pkg::*;
#(
  parameter int NUM_BANKS  = 8,
  parameter int BA_W       = 3,
  parameter int TPW        = 5,
  parameter int CYCLE_TRRD = DEF_CYCLE_TRRD,
  parameter int CYCLE_TCCD = DEF_CYCLE_TCCD,
  parameter int CYCLE_TRP  = DEF_CYCLE_TRP,
  parameter int CYCLE_TRFC = DEF_CYCLE_TRFC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_BANKS-1:0]     req_valid,
  input  logic [NUM_BANKS*2-1:0]   req_cmd,
  output logic [NUM_BANKS-1:0]     req_ready,
  input  logic [NUM_BANKS*TPW-1:0] bank_tp_cnt,
  input  logic [NUM_BANKS-1:0]     bank_open,
  input  logic                     refresh_req,
  output logic                     refresh_ack,
  output logic                     refresh_busy,
  output logic                     cmd_valid,
  output cmd_type_t                cmd_type,
  output logic [BA_W-1:0]          cmd_bank
);

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  sched_state_t         state_q, state_d;
  logic [CNT_W-1:0]     trrd_cnt, tccd_cnt, trp_cnt, trfc_cnt;
  logic [BA_W-1:0]      rr_ptr;
  logic [NUM_BANKS-1:0] elig, grant;
  logic [BA_W-1:0]      gnt_idx;
  logic                 any_grant;
  req_cmd_t             gnt_cmd;
  logic                 arb_open, tp_all_zero;

  logic                 cmd_vld_p1, ack_p1;
  cmd_type_t            cmd_type_p1;
  logic [BA_W-1:0]      cmd_bank_p1;

  assign tp_all_zero = (bank_tp_cnt == '0);
  // A pending refresh blocks grants in the very cycle it is seen.
  assign arb_open    = (state_q == ST_NORMAL) && !refresh_req;

  always_comb begin
    elig = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (arb_open && req_valid[b] && (bank_tp_cnt[b*TPW +: TPW] == '0)) begin
        case (req_cmd_t'(req_cmd[2*b +: 2]))
          REQ_ACT:        elig[b] = (trrd_cnt == '0);
          REQ_RD, REQ_WR: elig[b] = (tccd_cnt == '0);
          default:        elig[b] = 1'b1;
        endcase
      end
    end
  end

  bank_cmd_scheduler_rr_arbiter #(
    .NUM_BANKS(NUM_BANKS),
    .BA_W     (BA_W)
  ) u_arb (
    .elig     (elig),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .grant_idx(gnt_idx),
    .any_grant(any_grant)
  );

  assign gnt_cmd      = req_cmd_t'(req_cmd[{gnt_idx, 1'b0} +: 2]);
  assign req_ready    = grant & {NUM_BANKS{~rst}};
  assign refresh_busy = (state_q != ST_NORMAL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL:  if (refresh_req) state_d = ST_DRAIN;
      ST_DRAIN:   if (tp_all_zero && (tccd_cnt == '0))
                    state_d = (|bank_open) ? ST_PREA : ST_REF;
      ST_PREA:    state_d = ST_WAIT_RP;
      ST_WAIT_RP: if (trp_cnt == '0) state_d = ST_REF;
      ST_REF:     state_d = ST_TRFC;
      ST_TRFC:    if (trfc_cnt == '0) state_d = ST_NORMAL;
      default:    state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      rr_ptr   <= '0;
      trrd_cnt <= '0;
      tccd_cnt <= '0;
      trp_cnt  <= '0;
      trfc_cnt <= '0;
    end else begin
      state_q  <= state_d;
      if (any_grant) rr_ptr <= gnt_idx + 1'b1;
      trrd_cnt <= (any_grant && gnt_cmd == REQ_ACT) ? CNT_W'(CYCLE_TRRD - 1) : sat_dec(trrd_cnt);
      tccd_cnt <= (any_grant && (gnt_cmd == REQ_RD || gnt_cmd == REQ_WR))
                  ? CNT_W'(CYCLE_TCCD - 1) : sat_dec(tccd_cnt);
      trp_cnt  <= (state_q == ST_PREA) ? CNT_W'(CYCLE_TRP - 1) : sat_dec(trp_cnt);
      trfc_cnt <= (state_q == ST_REF) ? CNT_W'(CYCLE_TRFC - 1) : sat_dec(trfc_cnt);
    end
  end

  // Stage p0 -> p1: register the selected command onto the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_vld_p1  <= 1'b0;
      cmd_type_p1 <= CMD_NOP;
      cmd_bank_p1 <= '0;
      ack_p1      <= 1'b0;
    end else begin
      cmd_vld_p1 <= any_grant || (state_q == ST_PREA) || (state_q == ST_REF);
      ack_p1     <= (state_q == ST_REF);
      if (any_grant) begin
        cmd_type_p1 <= to_bus_cmd(gnt_cmd);
        cmd_bank_p1 <= gnt_idx;
      end else if (state_q == ST_PREA) begin
        cmd_type_p1 <= CMD_PREA;
        cmd_bank_p1 <= '0;
      end else if (state_q == ST_REF) begin
        cmd_type_p1 <= CMD_REF;
        cmd_bank_p1 <= '0;
      end else begin
        cmd_type_p1 <= CMD_NOP;
        cmd_bank_p1 <= '0;
      end
    end
  end

  assign cmd_valid   = cmd_vld_p1;
  assign cmd_type    = cmd_type_p1;
  assign cmd_bank    = cmd_bank_p1;
  assign refresh_ack = ack_p1;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Directed bench for bank_cmd_scheduler with a cycle-timestamp reference model.
module tb_bank_cmd_scheduler;
  localparam int NB = 8, BA_W = 3, TPW = 5;
  localparam int TRRD = 4, TCCD = 4, TRP = 10, TRFC = 88;

  logic clk = 1'b0;
  logic rst;
  logic [NB-1:0]     req_valid, req_ready, bank_open;
  logic [2*NB-1:0]   req_cmd;
  logic [NB*TPW-1:0] bank_tp_cnt;
  logic              refresh_req, refresh_ack, refresh_busy, cmd_valid;
  logic [2:0]        cmd_type;
  logic [BA_W-1:0]   cmd_bank;

  int n_cmp = 0, n_bad = 0;
  bit consume;

  always #5 clk = ~clk;

  bank_cmd_scheduler #(
    .NUM_BANKS(NB), .BA_W(BA_W), .TPW(TPW),
    .CYCLE_TRRD(TRRD), .CYCLE_TCCD(TCCD), .CYCLE_TRP(TRP), .CYCLE_TRFC(TRFC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
    .bank_tp_cnt(bank_tp_cnt), .bank_open(bank_open),
    .refresh_req(refresh_req), .refresh_ack(refresh_ack), .refresh_busy(refresh_busy),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: legality from cycle timestamps, refresh from scheduled cycles.
  int m_cyc, m_last_act, m_last_rw, m_ptr, m_prea_at, m_ref_at, m_norm_at, m_g, m_bi;
  bit m_on = 1'b0, m_in_ref, m_drained, m_busy;
  logic m_v, m_ack;
  logic [2:0] m_t;
  logic [BA_W-1:0] m_b;
  logic [NB-1:0] m_ready;
  logic [1:0] m_c;

  function automatic bit legal(input int b);
    logic [1:0] c;
    c = req_cmd[2*b +: 2];
    if (!req_valid[b] || bank_tp_cnt[TPW*b +: TPW] != 0) return 1'b0;
    if (c == 2'd0) return (m_cyc - m_last_act) >= TRRD;
    if (c == 2'd3) return 1'b1;
    return (m_cyc - m_last_rw) >= TCCD;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_cyc = 0; m_last_act = -1000; m_last_rw = -1000; m_ptr = 0;
      m_in_ref = 1'b0; m_drained = 1'b0; m_v = 1'b0; m_t = 3'd0; m_b = '0; m_ack = 1'b0;
      chk("rst_ready", req_ready, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_type", cmd_type, 0);
      chk("rst_cmd_bank", cmd_bank, 0);
      chk("rst_ack", refresh_ack, 0);
      chk("rst_busy", refresh_busy, 0);
    end else if (m_on) begin
      m_busy = m_in_ref;
      m_ready = '0;
      m_g = -1;
      if (!m_in_ref) begin
        if (refresh_req) begin
          m_in_ref = 1'b1;
          m_drained = 1'b0;
        end else begin
          for (int k = 0; k < NB; k++) begin
            m_bi = (m_ptr + k) % NB;
            if (m_g < 0 && legal(m_bi)) m_g = m_bi;
          end
        end
      end else if (!m_drained && bank_tp_cnt == '0 && (m_cyc - m_last_rw) >= TCCD) begin
        m_drained = 1'b1;
        if (bank_open != '0) begin
          m_prea_at = m_cyc + 1;
          m_ref_at  = m_cyc + 2 + TRP;
        end else begin
          m_prea_at = -1;
          m_ref_at  = m_cyc + 1;
        end
        m_norm_at = m_ref_at + TRFC + 1;
      end
      if (m_g >= 0) m_ready[m_g] = 1'b1;

      chk("model_ready", req_ready, m_ready);
      chk("model_busy", refresh_busy, m_busy);
      chk("model_cmd_valid", cmd_valid, m_v);
      chk("model_cmd_type", cmd_type, m_t);
      chk("model_cmd_bank", cmd_bank, m_b);
      chk("model_ack", refresh_ack, m_ack);

      m_v = 1'b0; m_t = 3'd0; m_b = '0; m_ack = 1'b0;
      if (m_g >= 0) begin
        m_c = req_cmd[2*m_g +: 2];
        m_v = 1'b1;
        m_t = 3'(m_c) + 3'd1;
        m_b = BA_W'(m_g);
        if (m_c == 2'd0) m_last_act = m_cyc;
        else if (m_c != 2'd3) m_last_rw = m_cyc;
        m_ptr = (m_g + 1) % NB;
      end else if (m_drained && m_cyc == m_prea_at) begin
        m_v = 1'b1; m_t = 3'd5;
      end else if (m_drained && m_cyc == m_ref_at) begin
        m_v = 1'b1; m_t = 3'd6; m_ack = 1'b1;
      end
      if (m_drained && m_cyc + 1 == m_norm_at) m_in_ref = 1'b0;
      m_cyc++;
    end
  end

  task automatic adv();
    logic [NB-1:0] g;
    g = req_ready;
    @(posedge clk); #1;
    if (consume) req_valid = req_valid & ~g;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; req_cmd = '0; bank_tp_cnt = '0; bank_open = '0; refresh_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [7:0] exp2 [9] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h01};
  logic [7:0] exp4 [4] = '{8'h10, 8'h00, 8'h00, 8'h04};

  initial begin
    logic [7:0] e;
    int busy_all, busy_after;
    rst = 1'b1; req_valid = '0; req_cmd = '0; bank_tp_cnt = '0; bank_open = '0;
    refresh_req = 1'b0; consume = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_cmd_valid", cmd_valid, 0);
    chk("init_cmd_type", cmd_type, 0);
    chk("init_req_ready", req_ready, 0);

    // 1: single ACT on bank 3
    do_reset(); consume = 1'b1; req_valid = 8'h08; req_cmd = '0;
    @(negedge clk); chk("t1_ready", req_ready, 8'h08); adv();
    @(negedge clk);
    chk("t1_cmd_valid", cmd_valid, 1); chk("t1_cmd_type", cmd_type, 1); chk("t1_cmd_bank", cmd_bank, 3);
    adv();
    @(negedge clk); chk("t1_valid_one_cycle", cmd_valid, 0); adv();

    // 2: banks 0 and 5 ACT continuously, tRRD spacing and pointer wrap
    do_reset(); consume = 1'b0; req_valid = 8'h21; req_cmd = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); chk("t2_ready", req_ready, exp2[c]); adv();
    end

    // 3: all banks RD continuously, tCCD spacing and wrap to bank 0
    do_reset(); consume = 1'b0; req_valid = 8'hFF; req_cmd = 16'h5555;
    for (int c = 0; c < 37; c++) begin
      e = (c % 4 == 0) ? 8'(1 << ((c / 4) % 8)) : 8'h00;
      @(negedge clk); chk("t3_ready", req_ready, e); adv();
    end

    // 4: bank 2 RD waits on its tP counter, bank 4 PRE goes first
    do_reset(); consume = 1'b1; req_valid = 8'h14; req_cmd = 16'h0310;
    for (int c = 0; c < 4; c++) begin
      bank_tp_cnt[2*TPW +: TPW] = 5'(3 - c);
      @(negedge clk);
      chk("t4_ready", req_ready, exp4[c]);
      if (c == 1) begin chk("t4_pre_type", cmd_type, 4); chk("t4_pre_bank", cmd_bank, 4); end
      adv();
    end
    @(negedge clk); chk("t4_rd_type", cmd_type, 2); chk("t4_rd_bank", cmd_bank, 2); adv();

    // 5: refresh with bank 1 open and its RD pending
    do_reset(); consume = 1'b1; bank_open = 8'h02; req_valid = 8'h02; req_cmd = 16'h0004;
    refresh_req = 1'b1; busy_all = 0; busy_after = 0;
    for (int c = 0; c < 104; c++) begin
      @(negedge clk);
      if (c == 0) chk("t5_no_grant", req_ready, 0);
      if (c == 3) chk("t5_prea", cmd_type, 5);
      if (c == 14) begin chk("t5_ack", refresh_ack, 1); chk("t5_ref", cmd_type, 6); end
      if (c == 102) chk("t5_resume", req_ready, 8'h02);
      if (c == 103) begin chk("t5_rd_type", cmd_type, 2); chk("t5_rd_bank", cmd_bank, 1); end
      busy_all += int'(refresh_busy);
      if (c >= 14) busy_after += int'(refresh_busy);
      adv();
      if (c == 14) refresh_req = 1'b0;
    end
    chk("t5_busy_total", busy_all, 101);
    chk("t5_busy_after_ref", busy_after, 88);

    // 6: reset asserted while waiting out tRFC
    do_reset(); consume = 1'b1; bank_open = '0; req_valid = 8'h02; req_cmd = 16'h0004;
    refresh_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin chk("t6_ack", refresh_ack, 1); chk("t6_ref", cmd_type, 6); end
      if (c == 9) chk("t6_busy_before", refresh_busy, 1);
      adv();
      if (c == 3) refresh_req = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", cmd_valid, 0);
    chk("t6_async_type", cmd_type, 0);
    chk("t6_async_bank", cmd_bank, 0);
    chk("t6_async_ack", refresh_ack, 0);
    chk("t6_async_busy", refresh_busy, 0);
    chk("t6_async_ready", req_ready, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk("t6_after_ready", req_ready, 8'h02); adv();
    @(negedge clk); chk("t6_after_type", cmd_type, 2); chk("t6_after_bank", cmd_bank, 1); adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
